// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory access controller with stall and MEM/WB register.
//
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to add an 8-bit watchdog that
// abandons a memory access after 255 BUSY cycles without dm_ack.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-low reset
//   valid_M, dm2reg_M, we_dm_M  MEM-stage valid / load / store
//   alu_out_M, wd_dm_M        effective address (or ALU result), store data
//   dm_ack, dm_rdata          memory completion and load data
//   dm_req, dm_we, dm_addr, dm_wdata  memory request
//   stall_M                   hold EX/MEM and upstream stages
//   valid_W, dm2reg_W, alu_out_W, rd_dm_W  MEM/WB register
//   misalign_W, timeout_W     retire status flags
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_M,
  input  logic        dm2reg_M,
  input  logic        we_dm_M,
  input  logic [31:0] alu_out_M,
  input  logic [31:0] wd_dm_M,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        stall_M,
  output logic        valid_W,
  output logic        dm2reg_W,
  output logic [31:0] alu_out_W,
  output logic [31:0] rd_dm_W,
  output logic        misalign_W,
  output logic        timeout_W
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;
  logic mem_op, aligned, misaligned, tmo;
  assign mem_op     = valid_M & (dm2reg_M | we_dm_M);
  assign aligned    = alu_out_M[1:0] == 2'b00;
  assign misaligned = mem_op & ~aligned;
  assign dm_we      = we_dm_M;
  assign dm_addr    = alu_out_M;
  assign dm_wdata   = wd_dm_M;
`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [7:0] cnt;
  // Counter sits at zero outside BUSY, so it is already clear on entry.
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (state == BUSY && !dm_ack) cnt <= cnt + 8'd1;
    else cnt <= '0;
  // An ack arriving at count 255 takes priority over the timeout.
  assign tmo = (state == BUSY) & ~dm_ack & (cnt == 8'hff);
  always_ff @(posedge clk or negedge rst)
    if (!rst) timeout_W <= 1'b0;
    else if (!stall_M) timeout_W <= tmo;
`else
  assign tmo       = 1'b0;
  assign timeout_W = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = (state == IDLE) ? ((mem_op & aligned) ? BUSY : IDLE)
                                : ((dm_ack | tmo) ? IDLE : BUSY);
  // Stall is forced low during reset even though inputs may show a memory op.
  always_comb begin
    dm_req  = state == BUSY;
    stall_M = rst & ((state == IDLE) ? (mem_op & aligned) : (~dm_ack & ~tmo));
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      valid_W    <= 1'b0;
      dm2reg_W   <= 1'b0;
      alu_out_W  <= '0;
      misalign_W <= 1'b0;
    end else if (stall_M) begin
      valid_W <= 1'b0;
    end else begin
      valid_W    <= valid_M & ~misaligned & ~tmo;
      dm2reg_W   <= dm2reg_M;
      alu_out_W  <= alu_out_M;
      misalign_W <= misaligned;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) rd_dm_W <= '0;
    else if (state == BUSY && dm_ack && !we_dm_M) rd_dm_W <= dm_rdata;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed self-checking bench for mem_access_ctrl.
module tb_mem_access_ctrl;
  logic        clk = 0, rst = 0;
  logic        valid_M = 0, dm2reg_M = 0, we_dm_M = 0, dm_ack = 0;
  logic [31:0] alu_out_M = 0, wd_dm_M = 0, dm_rdata = 0;
  logic        dm_req, dm_we, stall_M, valid_W, dm2reg_W, misalign_W, timeout_W;
  logic [31:0] dm_addr, dm_wdata, alu_out_W, rd_dm_W;
  int pass = 0, total = 0;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .valid_M(valid_M), .dm2reg_M(dm2reg_M), .we_dm_M(we_dm_M),
    .alu_out_M(alu_out_M), .wd_dm_M(wd_dm_M), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .stall_M(stall_M), .valid_W(valid_W), .dm2reg_W(dm2reg_W), .alu_out_W(alu_out_W),
    .rd_dm_W(rd_dm_W), .misalign_W(misalign_W), .timeout_W(timeout_W)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic ld, input logic st, input logic [31:0] a, input logic [31:0] wd);
    valid_M = v; dm2reg_M = ld; we_dm_M = st; alu_out_M = a; wd_dm_M = wd;
  endtask

  task automatic test_reset;
    drive(1, 1, 0, 32'h10, 0);
    #2;
    total++; if (dm_req !== 1'b0) $display("FAIL rst_req got=%b exp=0", dm_req); else pass++;
    total++; if (stall_M !== 1'b0) $display("FAIL rst_stall got=%b exp=0", stall_M); else pass++;
    step;
    total++; if (valid_W !== 1'b0) $display("FAIL rst_valid_W got=%b exp=0", valid_W); else pass++;
    total++; if (rd_dm_W !== 32'h0) $display("FAIL rst_rd_dm_W got=%h exp=0", rd_dm_W); else pass++;
    total++; if (misalign_W !== 1'b0 || timeout_W !== 1'b0) $display("FAIL rst_flags got=%b%b exp=00", misalign_W, timeout_W); else pass++;
    drive(0, 0, 0, 0, 0);
    rst = 1;
  endtask

  task automatic test_load;
    drive(1, 1, 0, 32'h10, 0);
    #1;
    total++; if (stall_M !== 1'b1 || dm_req !== 1'b0) $display("FAIL ld_launch got stall=%b req=%b exp stall=1 req=0", stall_M, dm_req); else pass++;
    step;
    total++; if (dm_req !== 1'b1 || stall_M !== 1'b1 || dm_addr !== 32'h10 || dm_we !== 1'b0) $display("FAIL ld_busy got req=%b stall=%b addr=%h we=%b", dm_req, stall_M, dm_addr, dm_we); else pass++;
    total++; if (valid_W !== 1'b0) $display("FAIL ld_bubble got=%b exp=0", valid_W); else pass++;
    step;
    dm_ack = 1; dm_rdata = 32'hDEADBEEF;
    #1;
    total++; if (stall_M !== 1'b0) $display("FAIL ld_ack_stall got=%b exp=0", stall_M); else pass++;
    step;
    dm_ack = 0; drive(0, 0, 0, 0, 0);
    total++; if (rd_dm_W !== 32'hDEADBEEF) $display("FAIL ld_rd got=%h exp=deadbeef", rd_dm_W); else pass++;
    total++; if (valid_W !== 1'b1 || dm2reg_W !== 1'b1 || alu_out_W !== 32'h10) $display("FAIL ld_retire got v=%b ld=%b a=%h exp 1 1 10", valid_W, dm2reg_W, alu_out_W); else pass++;
    total++; if (dm_req !== 1'b0) $display("FAIL ld_idle_req got=%b exp=0", dm_req); else pass++;
  endtask

  task automatic test_store;
    drive(1, 0, 1, 32'h20, 32'h12345678);
    step;
    for (int i = 0; i < 4; i++) begin
      total++; if (dm_req !== 1'b1 || dm_we !== 1'b1 || dm_wdata !== 32'h12345678 || stall_M !== 1'b1) $display("FAIL st_busy%0d got req=%b we=%b wd=%h stall=%b", i, dm_req, dm_we, dm_wdata, stall_M); else pass++;
      step;
      total++; if (valid_W !== 1'b0) $display("FAIL st_bubble%0d got=%b exp=0", i, valid_W); else pass++;
    end
    dm_ack = 1;
    #1;
    total++; if (dm_req !== 1'b1 || stall_M !== 1'b0) $display("FAIL st_ack got req=%b stall=%b exp 1 0", dm_req, stall_M); else pass++;
    step;
    dm_ack = 0; drive(0, 0, 0, 0, 0);
    total++; if (valid_W !== 1'b1 || dm2reg_W !== 1'b0 || alu_out_W !== 32'h20) $display("FAIL st_retire got v=%b ld=%b a=%h exp 1 0 20", valid_W, dm2reg_W, alu_out_W); else pass++;
    total++; if (rd_dm_W !== 32'hDEADBEEF) $display("FAIL st_rd_hold got=%h exp=deadbeef", rd_dm_W); else pass++;
  endtask

  task automatic test_misalign;
    drive(1, 1, 0, 32'h13, 0);
    #1;
    total++; if (dm_req !== 1'b0 || stall_M !== 1'b0) $display("FAIL mis_nostall got req=%b stall=%b exp 0 0", dm_req, stall_M); else pass++;
    step;
    total++; if (misalign_W !== 1'b1 || valid_W !== 1'b0 || dm_req !== 1'b0) $display("FAIL mis_retire got mis=%b v=%b req=%b exp 1 0 0", misalign_W, valid_W, dm_req); else pass++;
    drive(0, 0, 0, 0, 0);
    step;
    total++; if (misalign_W !== 1'b0) $display("FAIL mis_clear got=%b exp=0", misalign_W); else pass++;
  endtask

  task automatic test_ack_idle;
    dm_ack = 1; dm_rdata = 32'h55555555;
    #1;
    total++; if (dm_req !== 1'b0 || stall_M !== 1'b0) $display("FAIL idleack_out got req=%b stall=%b exp 0 0", dm_req, stall_M); else pass++;
    step;
    dm_ack = 0;
    total++; if (rd_dm_W !== 32'hDEADBEEF) $display("FAIL idleack_rd got=%h exp=deadbeef", rd_dm_W); else pass++;
  endtask

  task automatic test_reset_busy;
    drive(1, 1, 0, 32'h40, 0);
    step; step; step;
    total++; if (dm_req !== 1'b1) $display("FAIL rb_busy got=%b exp=1", dm_req); else pass++;
    rst = 0;
    #1;
    total++; if (dm_req !== 1'b0 || stall_M !== 1'b0 || valid_W !== 1'b0 || rd_dm_W !== 32'h0) $display("FAIL rb_async got req=%b stall=%b v=%b rd=%h", dm_req, stall_M, valid_W, rd_dm_W); else pass++;
    drive(1, 0, 0, 32'h99, 0);
    step;
    rst = 1;
    #1;
    total++; if (stall_M !== 1'b0 || dm_req !== 1'b0) $display("FAIL rb_idle got stall=%b req=%b exp 0 0", stall_M, dm_req); else pass++;
    step;
    drive(0, 0, 0, 0, 0);
    total++; if (valid_W !== 1'b1 || alu_out_W !== 32'h99 || dm2reg_W !== 1'b0) $display("FAIL rb_alu got v=%b a=%h ld=%b exp 1 99 0", valid_W, alu_out_W, dm2reg_W); else pass++;
  endtask

  task automatic test_back_to_back;
    drive(1, 1, 0, 32'h100, 0);
    step;
    total++; if (valid_W !== 1'b0) $display("FAIL b2b_c1 got=%b exp=0", valid_W); else pass++;
    dm_ack = 1; dm_rdata = 32'hA1A1A1A1;
    step;
    total++; if (valid_W !== 1'b1 || rd_dm_W !== 32'hA1A1A1A1 || alu_out_W !== 32'h100) $display("FAIL b2b_first got v=%b rd=%h a=%h", valid_W, rd_dm_W, alu_out_W); else pass++;
    dm_ack = 0; drive(1, 1, 0, 32'h104, 0);
    #1;
    total++; if (stall_M !== 1'b1 || dm_req !== 1'b0) $display("FAIL b2b_launch2 got stall=%b req=%b exp 1 0", stall_M, dm_req); else pass++;
    step;
    total++; if (valid_W !== 1'b0) $display("FAIL b2b_c3 got=%b exp=0", valid_W); else pass++;
    dm_ack = 1; dm_rdata = 32'hB2B2B2B2;
    step;
    dm_ack = 0; drive(0, 0, 0, 0, 0);
    total++; if (valid_W !== 1'b1 || rd_dm_W !== 32'hB2B2B2B2 || alu_out_W !== 32'h104) $display("FAIL b2b_second got v=%b rd=%h a=%h", valid_W, rd_dm_W, alu_out_W); else pass++;
    step;
    total++; if (valid_W !== 1'b0) $display("FAIL b2b_nodup got=%b exp=0", valid_W); else pass++;
  endtask

  task automatic test_timeout;
    int n;
`ifdef MEM_ACCESS_TIMEOUT_EN
    drive(1, 1, 0, 32'h200, 0);
    dm_rdata = 32'hCCCCCCCC;
    #1;
    n = 0;
    while (stall_M && n < 400) begin n++; step; end
    total++; if (n !== 256) $display("FAIL to_stall_cycles got=%0d exp=256", n); else pass++;
    step;
    total++; if (timeout_W !== 1'b1 || valid_W !== 1'b0 || rd_dm_W !== 32'hB2B2B2B2) $display("FAIL to_retire got to=%b v=%b rd=%h", timeout_W, valid_W, rd_dm_W); else pass++;
    total++; if (dm_req !== 1'b0 || stall_M !== 1'b1) $display("FAIL to_relaunch got req=%b stall=%b exp 0 1", dm_req, stall_M); else pass++;
    for (int i = 0; i < 256; i++) step;
    dm_ack = 1; dm_rdata = 32'hE0E0E0E0;
    #1;
    total++; if (dm_req !== 1'b1 || stall_M !== 1'b0) $display("FAIL to_ack255 got req=%b stall=%b exp 1 0", dm_req, stall_M); else pass++;
    step;
    dm_ack = 0; drive(0, 0, 0, 0, 0);
    total++; if (timeout_W !== 1'b0 || valid_W !== 1'b1 || rd_dm_W !== 32'hE0E0E0E0) $display("FAIL to_ackwin got to=%b v=%b rd=%h", timeout_W, valid_W, rd_dm_W); else pass++;
`else
    drive(1, 1, 0, 32'h200, 0);
    n = 0;
    for (int i = 0; i < 300; i++) begin step; if (stall_M && dm_req) n++; end
    total++; if (n !== 300) $display("FAIL nto_wait got=%0d exp=300", n); else pass++;
    total++; if (timeout_W !== 1'b0 || valid_W !== 1'b0) $display("FAIL nto_flags got to=%b v=%b exp 0 0", timeout_W, valid_W); else pass++;
    dm_ack = 1; dm_rdata = 32'hE0E0E0E0;
    step;
    dm_ack = 0; drive(0, 0, 0, 0, 0);
    total++; if (valid_W !== 1'b1 || rd_dm_W !== 32'hE0E0E0E0 || timeout_W !== 1'b0) $display("FAIL nto_done got v=%b rd=%h to=%b", valid_W, rd_dm_W, timeout_W); else pass++;
`endif
  endtask

  initial begin
    step;
    test_reset;
    step;
    test_load;
    test_store;
    test_misalign;
    test_ack_idle;
    test_reset_busy;
    test_back_to_back;
    test_timeout;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
